// File: rtl/usrt_xfer_ctrl.sv
// usrt_xfer_ctrl: APB-side transfer controller for the USRT link.
// Each APB access to the data register sequences one serial frame
// (start, 8 data bits LSB first, even parity, stop). The APB transfer is
// stretched with pReady until the frame completes. The status register
// holds sticky error flags that clear when it is read.
module usrt_xfer_ctrl #(
  parameter int unsigned DIV     = 80,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       pClk,
  input  logic       pReset,
  input  logic       pSelect,
  input  logic       pEnable,
  input  logic       pWrite,
  input  logic [7:0] pAddr,
  input  logic [7:0] pWData,
  output logic [7:0] pRData,
  output logic       pReady,
  output logic       pSlvErr,
  output logic       txd,
  input  logic       rxd,
  output logic       uClk,
  output logic       dir
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TX_BITS = 11;  // start + 8 data + parity + stop
  localparam int unsigned RX_BITS = 10;  // 8 data + parity + stop after the start bit
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned STAT_W  = 4;

  localparam logic [7:0] ADDR_DATA = 8'h00;
  localparam logic [7:0] ADDR_STAT = 8'h01;

  // Status bit positions: {abort, timeout, frame_err, parity_err}
  localparam int unsigned ST_PAR   = 0;
  localparam int unsigned ST_FRM   = 1;
  localparam int unsigned ST_TO    = 2;
  localparam int unsigned ST_ABORT = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_SHIFT = 3'd1,
    S_RX_HUNT  = 3'd2,
    S_RX_SHIFT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [CNT_W-1:0]      r_baud;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [TX_BITS-1:0]    r_tx_sh;
  logic [DATA_W-1:0]     r_rx_sh;
  logic                  r_rx_par;
  logic [DATA_W-1:0]     r_rx_data;
  logic [STAT_W-1:0]     r_status;
  logic                  r_xfer_wr;
  logic                  r_xfer_err;

  logic w_idle;
  logic w_busy;
  logic w_access;
  logic w_data_acc;
  logic w_stat_rd;
  logic w_bad_acc;
  logic w_tick;
  logic w_abort;
  logic w_tx_last;
  logic w_rx_last;
  logic w_to_last;
  logic w_tx_end;
  logic w_hunt_start;
  logic w_hunt_to;
  logic w_rx_end;
  logic w_rx_perr;
  logic w_rx_ferr;

  // APB access decode and frame-progress conditions
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_busy       = (r_state == S_TX_SHIFT) || (r_state == S_RX_HUNT) ||
                   (r_state == S_RX_SHIFT);
    w_access     = pSelect && pEnable;
    w_data_acc   = w_idle && w_access && (pAddr == ADDR_DATA);
    w_stat_rd    = w_idle && w_access && !pWrite && (pAddr == ADDR_STAT);
    w_bad_acc    = w_idle && w_access && !(pAddr == ADDR_DATA) && !w_stat_rd;
    w_tick       = w_busy && (r_baud == CNT_W'(DIV - 1));
    w_abort      = w_busy && !pSelect;
    w_tx_last    = (r_bit_cnt == BIT_W'(TX_BITS - 1));
    w_rx_last    = (r_bit_cnt == BIT_W'(RX_BITS - 1));
    w_to_last    = (r_to_cnt == TO_W'(TIMEOUT - 1));
    w_tx_end     = (r_state == S_TX_SHIFT) && w_tick && w_tx_last && !w_abort;
    w_hunt_start = (r_state == S_RX_HUNT) && w_tick && !rxd && !w_abort;
    w_hunt_to    = (r_state == S_RX_HUNT) && w_tick && rxd && w_to_last && !w_abort;
    w_rx_end     = (r_state == S_RX_SHIFT) && w_tick && w_rx_last && !w_abort;
    // Stop bit is the live rxd sample on the final receive tick
    w_rx_perr    = (r_rx_par != ^r_rx_sh);
    w_rx_ferr    = !rxd;
  end

  // FSM state register
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; abort (pSelect dropped) wins over frame progress
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_data_acc) begin
          w_state_nxt = pWrite ? S_TX_SHIFT : S_RX_HUNT;
        end
      end
      S_TX_SHIFT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tx_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_RX_HUNT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_hunt_start) begin
          w_state_nxt = S_RX_SHIFT;
        end else if (w_hunt_to) begin
          w_state_nxt = S_DONE;
        end
      end
      S_RX_SHIFT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_rx_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM outputs: APB response and serial pins
  always_comb begin
    pReady  = 1'b0;
    pRData  = '0;
    pSlvErr = 1'b0;
    txd     = 1'b1;
    dir     = 1'b0;
    uClk    = 1'b0;
    case (r_state)
      S_IDLE: begin
        pReady  = !w_data_acc;
        pSlvErr = w_bad_acc;
        if (w_stat_rd) begin
          pRData = {(DATA_W - STAT_W)'(0), r_status};
        end
      end
      S_TX_SHIFT: begin
        txd  = r_tx_sh[0];
        dir  = 1'b1;
        uClk = w_tick;
      end
      S_RX_HUNT, S_RX_SHIFT: begin
        uClk = w_tick;
      end
      S_DONE: begin
        pReady = 1'b1;
        if (!r_xfer_wr) begin
          pRData  = r_rx_data;
          pSlvErr = r_xfer_err;
        end
      end
      default: begin
        pReady = 1'b0;
      end
    endcase
  end

  // Baud counter: held at 0 outside the frame, restarts on every state change
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_baud <= '0;
    end else if (!w_busy || w_tick || (w_state_nxt != r_state)) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + CNT_W'(1);
    end
  end

  // Bit counter: ticks consumed in the current shift state
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_bit_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_bit_cnt <= '0;
    end else if (w_tick && ((r_state == S_TX_SHIFT) || (r_state == S_RX_SHIFT))) begin
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  // Timeout counter: idle-high ticks seen while hunting for a start bit
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_to_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_to_cnt <= '0;
    end else if (w_tick && (r_state == S_RX_HUNT)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Tx frame shifter: loaded with the whole frame, LSB goes out first
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_tx_sh <= '1;
    end else if (w_data_acc && pWrite) begin
      r_tx_sh <= {1'b1, ^pWData, pWData, 1'b0};
    end else if ((r_state == S_TX_SHIFT) && w_tick) begin
      r_tx_sh <= {1'b1, r_tx_sh[TX_BITS-1:1]};
    end
  end

  // Rx bit capture: 8 data bits LSB first, then the parity bit
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_rx_sh  <= '0;
      r_rx_par <= 1'b0;
    end else if ((r_state == S_RX_SHIFT) && w_tick) begin
      if (r_bit_cnt < BIT_W'(DATA_W)) begin
        r_rx_sh <= {rxd, r_rx_sh[DATA_W-1:1]};
      end else if (r_bit_cnt == BIT_W'(DATA_W)) begin
        r_rx_par <= rxd;
      end
    end
  end

  // Rx data register: received byte kept even on error, zero on timeout
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_rx_data <= '0;
    end else if (w_hunt_to) begin
      r_rx_data <= '0;
    end else if (w_rx_end) begin
      r_rx_data <= r_rx_sh;
    end
  end

  // Per-transfer tracking for the DONE response
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_xfer_wr  <= 1'b0;
      r_xfer_err <= 1'b0;
    end else if (w_data_acc) begin
      r_xfer_wr  <= pWrite;
      r_xfer_err <= 1'b0;
    end else if (w_hunt_to) begin
      r_xfer_err <= 1'b1;
    end else if (w_rx_end) begin
      r_xfer_err <= w_rx_perr || w_rx_ferr;
    end
  end

  // Sticky status flags; a status read only happens in IDLE so it never meets a set
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_status <= '0;
    end else if (w_stat_rd) begin
      r_status <= '0;
    end else begin
      if (w_abort) begin
        r_status[ST_ABORT] <= 1'b1;
      end
      if (w_hunt_to) begin
        r_status[ST_TO] <= 1'b1;
      end
      if (w_rx_end && w_rx_perr) begin
        r_status[ST_PAR] <= 1'b1;
      end
      if (w_rx_end && w_rx_ferr) begin
        r_status[ST_FRM] <= 1'b1;
      end
    end
  end

endmodule
